// File: rtl/register_pkg.sv
// Shared constants for the serial register link: FSM encoding and line levels.
package register_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_DATA = ST_DATA,
    S_STOP = ST_STOP
  } rx_state_t;

endpackage

// File: rtl/register_sipo_rx_frame_bit_counter.sv
// Data-bit counter for one frame: synchronous clear, count enable and a
// terminal flag raised while the count sits at WIDTH-1 (last data bit).
module frame_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CW    = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CW-1:0] r_cnt;

  // Count data bits; clear wins over enable so a new frame always starts at 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_tc = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/register_sipo_rx.sv
// Serial-in, parallel-out receiver: start bit, WIDTH data bits, stop bit,
// one bit per i_sin_en edge. Publishes the word only on a good stop bit.
module register_sipo_rx
  import register_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sin,
  input  logic             i_sin_en,
  output logic [WIDTH-1:0] o_out,
  output logic             o_valid,
  output logic             o_frame_err,
  output logic             o_busy
);

  rx_state_t        r_state;
  rx_state_t        w_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_clr;
  logic             w_cnt_en;
  logic             w_shift;
  logic             w_load;
  logic             w_ferr;
  logic             w_tc;

  // The counter stops at WIDTH-1 (the last data bit moves us to STOP instead),
  // so it never wraps inside a frame.
  frame_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  // Bit order: LSB-first shifts in from the top so the first bit ends in [0];
  // MSB-first shifts in from the bottom so the first bit ends in [WIDTH-1].
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign w_shift_nxt = {r_shift[WIDTH-2:0], i_sin};
    end else begin : g_lsb
      assign w_shift_nxt = {i_sin, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and per-edge strobes; nothing moves when i_sin_en is low.
  always_comb begin
    w_next   = r_state;
    w_clr    = 1'b0;
    w_cnt_en = 1'b0;
    w_shift  = 1'b0;
    w_load   = 1'b0;
    w_ferr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_sin_en && (i_sin == START_BIT)) begin
          w_next = S_DATA;
          w_clr  = 1'b1;
        end
      end
      S_DATA: begin
        if (i_sin_en) begin
          w_shift = 1'b1;
          if (w_tc) w_next   = S_STOP;
          else      w_cnt_en = 1'b1;
        end
      end
      S_STOP: begin
        if (i_sin_en) begin
          if (i_sin == LINE_IDLE) w_load = 1'b1;
          else                    w_ferr = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Internal shift register; never visible on o_out mid-frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_shift <= '0;
    else if (w_shift) r_shift <= w_shift_nxt;
  end

  // Registered outputs: word held between frames, one-cycle status pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_out       <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      if (w_load) o_out <= r_shift;
      o_valid     <= w_load;
      o_frame_err <= w_ferr;
      o_busy      <= (w_next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_register_sipo_rx.sv
// Directed bench: two receivers (LSB-first and MSB-first) share one serial
// line; a frame-level model predicts both on every cycle, and literal checks
// pin the model at the key points of each scenario.
module tb_register_sipo_rx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sin = 1'b1;
  logic         sin_en = 1'b0;
  logic [W-1:0] out_l, out_m;
  logic         vld_l, vld_m, ferr_l, ferr_m, busy_l, busy_m;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  register_sipo_rx #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .i_clk(clk), .i_rst(rst), .i_sin(sin), .i_sin_en(sin_en),
    .o_out(out_l), .o_valid(vld_l), .o_frame_err(ferr_l), .o_busy(busy_l));

  register_sipo_rx #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .i_clk(clk), .i_rst(rst), .i_sin(sin), .i_sin_en(sin_en),
    .o_out(out_m), .o_valid(vld_m), .o_frame_err(ferr_m), .o_busy(busy_m));

  // Model: n = number of frame bits consumed so far (0 = waiting for start).
  int           n = 0;
  logic [W-1:0] m_word_l = '0, m_word_m = '0;
  logic [W-1:0] e_out_l = '0, e_out_m = '0;
  logic         e_vld = 1'b0, e_ferr = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; m_word_l = '0; m_word_m = '0;
      e_out_l = '0; e_out_m = '0; e_vld = 1'b0; e_ferr = 1'b0;
    end else begin
      e_vld = 1'b0;
      e_ferr = 1'b0;
      if (sin_en) begin
        if (n == 0) begin
          if (sin == 1'b0) n = 1;
        end else if (n <= W) begin
          m_word_l[n-1] = sin;      // k-th data bit -> bit k
          m_word_m[W-n] = sin;      // k-th data bit -> bit W-1-k
          n = n + 1;
        end else begin
          if (sin) begin e_out_l = m_word_l; e_out_m = m_word_m; e_vld = 1'b1; end
          else e_ferr = 1'b1;
          n = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("out_l", 32'(out_l), 32'(e_out_l));
    chk("out_m", 32'(out_m), 32'(e_out_m));
    chk("valid_l", 32'(vld_l), 32'(e_vld));
    chk("valid_m", 32'(vld_m), 32'(e_vld));
    chk("ferr_l", 32'(ferr_l), 32'(e_ferr));
    chk("ferr_m", 32'(ferr_m), 32'(e_ferr));
    chk("busy_l", 32'(busy_l), 32'(n != 0));
    chk("busy_m", 32'(busy_m), 32'(n != 0));
    chk("vld_ferr_excl", 32'(vld_l & ferr_l), 32'd0);
  end

  task automatic step(input logic en, input logic b);
    sin_en = en;
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [W+1:0] bits); // bits[0] sent first
    for (int i = 0; i < W + 2; i++) step(1'b1, bits[i]);
  endtask

  logic [5:0] f;

  initial begin
    // Reset state
    repeat (2) step(1'b0, 1'b1);
    chk("rst_out", 32'(out_l), 32'h0);
    chk("rst_busy", 32'(busy_l), 32'h0);
    rst = 1'b0;
    step(1'b0, 1'b1);

    // Frame 0,0,1,0,1,1 -> 4'hA (LSB-first), 4'h5 (MSB-first)
    f = 6'b110100;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, f[i]);
      if (i < 5) chk("t1_busy", 32'(busy_l), 32'h1);
      if (i < 5) chk("t1_novld", 32'(vld_l), 32'h0);
    end
    chk("t1_out", 32'(out_l), 32'hA);
    chk("t1_outm", 32'(out_m), 32'h5);
    chk("t1_vld", 32'(vld_l), 32'h1);
    chk("t1_busy_end", 32'(busy_l), 32'h0);
    chk("t1_model", 32'(e_out_l), 32'hA);
    step(1'b1, 1'b1);
    chk("t1_vld_fall", 32'(vld_l), 32'h0);

    // Same frame with bad stop bit, then data F with bad stop: OUT holds A
    f = 6'b010100;
    frame(f);
    chk("t2_ferr", 32'(ferr_l), 32'h1);
    chk("t2_vld", 32'(vld_l), 32'h0);
    chk("t2_out", 32'(out_l), 32'hA);
    f = 6'b011110;
    frame(f);
    chk("t2b_ferr", 32'(ferr_l), 32'h1);
    chk("t2b_out", 32'(out_l), 32'hA);
    step(1'b1, 1'b1);
    chk("t2_ferr_fall", 32'(ferr_l), 32'h0);

    // 4'h3 with strobe every third cycle, random line toggles in between
    f = 6'b100110;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, f[i]);
      if (i == 5) begin
        chk("t3_vld", 32'(vld_l), 32'h1);
        chk("t3_out", 32'(out_l), 32'h3);
        chk("t3_outm", 32'(out_m), 32'hC);
      end
      step(1'b0, 1'($urandom_range(0, 1)));
      chk("t3_vld_once", 32'(vld_l), 32'h0);
      step(1'b0, 1'($urandom_range(0, 1)));
    end

    // Back-to-back 4'h3 then 4'hC, no idle bit
    f = 6'b100110;
    frame(f);
    chk("t4_vld1", 32'(vld_l), 32'h1);
    chk("t4_out1", 32'(out_l), 32'h3);
    f = 6'b111000;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, f[i]);
      if (i < 5) chk("t4_gap", 32'(vld_l), 32'h0);
    end
    chk("t4_vld2", 32'(vld_l), 32'h1);
    chk("t4_out2", 32'(out_l), 32'hC);
    chk("t4_out2m", 32'(out_m), 32'h3);

    // Abort after 2 data bits, then 4'h5
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_abort_out", 32'(out_l), 32'h0);
    chk("t5_abort_busy", 32'(busy_l), 32'h0);
    chk("t5_abort_vld", 32'(vld_l | ferr_l), 32'h0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    rst = 1'b0;
    f = 6'b110100 ^ 6'b011110; // 0,1,0,1,0,1 -> data 1,0,1,0
    frame(f);
    chk("t5_vld", 32'(vld_l), 32'h1);
    chk("t5_out", 32'(out_l), 32'h5);
    chk("t5_outm", 32'(out_m), 32'hA);

    // MSB-first data 1,0,0,0 -> 4'h8 (LSB-first sees 4'h1)
    f = 6'b100010;
    frame(f);
    chk("t6_outm", 32'(out_m), 32'h8);
    chk("t6_out", 32'(out_l), 32'h1);

    // Idle line for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1);
      chk("t6_idle", 32'({busy_l, vld_l, ferr_l}), 32'h0);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
